alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 35 +++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   alu_op_e      : 3-bit ALU opcodes, including the two illegal encodings
//   arb_state_e   : arbiter FSM states
//   is_illegal_op : true for the opcodes that must never reach the ALU
package alu_pkg;

    localparam int unsigned DataWidth  = 32;
    localparam int unsigned CountWidth = 16;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluOr   = 3'b010,
        AluAnd  = 3'b011,
        AluIll0 = 3'b100,
        AluNor  = 3'b101,
        AluNot  = 3'b110,
        AluIll1 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == AluIll0) || (op == AluIll1);
    endfunction

endpackage

// File: rtl/alu.sv
// Existing 32-bit ALU.
//   clk     : clock for the registered zero flag
//   a, b    : operands
//   ALU_op  : opcode (see alu_pkg::alu_op_e); unknown codes yield 0
//   ALU_res : combinational result
//   zero    : registered (ALU_res == 0) flag, one cycle behind ALU_res
import alu_pkg::*;

module alu (
    input  logic                 clk,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic [2:0]           ALU_op,
    output logic [DataWidth-1:0] ALU_res,
    output logic                 zero
);

    always_comb begin
        ALU_res = '0;
        case (ALU_op)
            AluAdd:  ALU_res = a + b;
            AluSub:  ALU_res = a - b;
            AluOr:   ALU_res = a | b;
            AluAnd:  ALU_res = a & b;
            AluNor:  ALU_res = ~(a | b);
            AluNot:  ALU_res = ~a;
            default: ALU_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        zero <= (ALU_res == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared ALU.
//   clk, rst                       : clock, synchronous active-high reset
//   reqN_valid/ready, a, b, op     : request handshake and operation for port N
//   rspN_valid/ready, res/zero/err : response handshake and result for port N
//   ops_count                      : number of completed responses (wraps)
// One transaction is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
import alu_pkg::*;

module alu_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DataWidth-1:0]  req0_a,
    input  logic [DataWidth-1:0]  req0_b,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DataWidth-1:0]  req1_a,
    input  logic [DataWidth-1:0]  req1_b,
    input  logic [2:0]            req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DataWidth-1:0]  rsp0_res,
    output logic                  rsp0_zero,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DataWidth-1:0]  rsp1_res,
    output logic                  rsp1_zero,
    output logic                  rsp1_err,
    output logic [CountWidth-1:0] ops_count
);

    arb_state_e            state_q;
    logic                  last_grant_q;
    logic                  owner_q;
    logic [DataWidth-1:0]  a_q, b_q, res_q;
    logic [2:0]            op_q;
    logic                  zero_q, err_q;
    logic [CountWidth-1:0] ops_count_q;

    logic                  gnt0, gnt1, owner_ready;
    logic [2:0]            alu_op;
    logic [DataWidth-1:0]  alu_res;
    logic                  alu_zero_unused;

    // On a tie the port that was not served last wins.
    assign gnt0 = req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = !rst && (state_q == StIdle) && gnt0;
    assign req1_ready = !rst && (state_q == StIdle) && gnt1;

    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Illegal opcodes never reach the ALU; it sees ADD outside EXEC as well.
    assign alu_op = ((state_q == StExec) && !is_illegal_op(op_q)) ? op_q : AluAdd;

    alu u_alu (
        .clk     (clk),
        .a       (a_q),
        .b       (b_q),
        .ALU_op  (alu_op),
        .ALU_res (alu_res),
        .zero    (alu_zero_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            ops_count_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        a_q          <= gnt1 ? req1_a  : req0_a;
                        b_q          <= gnt1 ? req1_b  : req0_b;
                        op_q         <= gnt1 ? req1_op : req0_op;
                        owner_q      <= gnt1;
                        last_grant_q <= gnt1;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    if (is_illegal_op(op_q)) begin
                        res_q  <= '0;
                        zero_q <= 1'b0;
                        err_q  <= 1'b1;
                    end else begin
                        res_q  <= alu_res;
                        zero_q <= (alu_res == '0);
                        err_q  <= 1'b0;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (owner_ready) begin
                        ops_count_q <= ops_count_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp0_valid = (state_q == StResp) && !owner_q;
    assign rsp1_valid = (state_q == StResp) && owner_q;

    assign rsp0_res  = rsp0_valid ? res_q  : '0;
    assign rsp0_zero = rsp0_valid ? zero_q : 1'b0;
    assign rsp0_err  = rsp0_valid ? err_q  : 1'b0;
    assign rsp1_res  = rsp1_valid ? res_q  : '0;
    assign rsp1_zero = rsp1_valid ? zero_q : 1'b0;
    assign rsp1_err  = rsp1_valid ? err_q  : 1'b0;

    assign ops_count = ops_count_q;

endmodule
